// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// in_ready decodes registered state only, so it has no combinational path from
// out_ready. The stage also counts downstream stall cycles.
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              accept;
  logic              fire;

  assign in_ready  = rst & (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign occupancy = state_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

  // Next-state and storage update: flush overrides the handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (fire && accept) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (fire) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        TWO: begin
          if (fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Saturating stall counter; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted entries are queued when issued,
// a monitor compares the DUT head, occupancy, ready and stall count each cycle.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ctrl = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_ctrl;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_stall_cnt;

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned mcnt  = 0;
  int unsigned mcnt2 = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the queue model mid-cycle, then advances the model.
  initial begin
    int unsigned sz;
    forever begin
      @(negedge clk);
      sz = exp_q.size();
      chk("occupancy", 64'(occupancy), 64'(sz));
      chk("out_valid", 64'(out_valid), 64'(sz != 0));
      chk("in_ready", 64'(in_ready), 64'(rst && sz < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
      chk("sat_stall_cnt", 64'(s_stall_cnt), 64'(mcnt2));
      chk("sat_occupancy", 64'(s_occupancy), 64'(sz));
      if (sz != 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
      end
      if (!rst) begin
        mcnt  = 0;
        mcnt2 = 0;
      end else if (sz != 0 && !out_ready) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (!rst || flush) exp_q.delete();
    end
  end

  // Issue side: record each entry the stage takes at the coming edge.
  always @(negedge clk) begin
    #1;
    if (rst && !flush && in_valid && in_ready) exp_q.push_back({in_data, in_ctrl});
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c,
                       input logic ordy, input logic fl, input logic r);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] c, input logic ordy);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      in_valid = 1'b1; in_data = d; in_ctrl = c; out_ready = ordy; flush = 1'b0; rst = 1'b1;
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected acceptance of %0h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 4'd0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset for two edges.
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) push(32'(i), 4'(i), 1'b1);
    idle(2, 1'b1);

    // Skid fill: A and B taken, C held upstream until space frees.
    push(32'hA, 4'h1, 1'b0);
    push(32'hB, 4'h2, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC, 4'h3, 1'b0, 1'b0, 1'b1);
    push(32'hC, 4'h3, 1'b1);
    idle(3, 1'b1);

    // Flush with occupancy 2 while D is offered.
    push(32'h101, 4'h4, 1'b0);
    push(32'h102, 4'h5, 1'b0);
    drive(1'b1, 32'hD, 4'hF, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Simultaneous fire and accept in ONE.
    push(32'h11, 4'h6, 1'b0);
    push(32'h22, 4'h7, 1'b1);
    idle(2, 1'b1);

    // Reset mid-operation with occupancy 2.
    push(32'h201, 4'h8, 1'b0);
    push(32'h202, 4'h9, 1'b0);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Counter saturation: one entry held for six stalled cycles.
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    push(32'h55, 4'hA, 1'b0);
    idle(6, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0, ($urandom % 100) != 0);
    end
    idle(4, 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
